// File: rtl/vga_sync_pkg.sv
// Shared 640x480@60 VGA timing constants and helpers, also used by the sprite,
// wall and bomberman blocks.
package vga_sync_pkg;

    typedef logic [9:0] coord_t;

    localparam int VGA_H_DISPLAY    = 640;
    localparam int VGA_H_FRONT      = 16;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BACK       = 48;
    localparam int VGA_H_TOTAL      = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

    localparam int VGA_V_DISPLAY    = 480;
    localparam int VGA_V_FRONT      = 10;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BACK       = 33;
    localparam int VGA_V_TOTAL      = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    localparam int VGA_CLK_DIV      = 4;

    // Half-open window test [lo, hi) on unsigned 10-bit coordinates.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Timing bundle driven by vga_sync and consumed by the pixel-generation blocks.
interface vga_sync_if;
    import vga_sync_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   p_tick;
    coord_t x;
    coord_t y;
    logic   line_start;
    logic   frame_start;

    modport master (
        output hsync, vsync, video_on, p_tick, x, y, line_start, frame_start
    );

    modport slave (
        input hsync, vsync, video_on, p_tick, x, y, line_start, frame_start
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Mod-CLK_DIV divider: o_tick is a registered one-clk pulse per pixel period;
// o_tick_pre flags the clk edge that raises it so callers can update in step.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick_pre,
    output logic o_tick
);

    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_tick;

    always_comb begin
        w_cnt_nxt  = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        o_tick_pre = (w_cnt_nxt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= o_tick_pre;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel divider, h/v counters and registered sync/visible
// flags that always describe the same pixel as the x/y outputs.
module vga_sync
    import vga_sync_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = VGA_CLK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);

    localparam int     H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int     V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
    localparam coord_t H_SS    = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t H_SE    = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t V_SS    = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t V_SE    = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam coord_t H_VIS   = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS   = coord_t'(V_DISPLAY);

    logic   w_tick_pre;
    logic   w_p_tick;
    logic   w_h_wrap;
    logic   w_v_wrap;
    coord_t w_h_nxt;
    coord_t w_v_nxt;

    coord_t r_h;
    coord_t r_v;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_video_on;
    logic   r_line_start;
    logic   r_frame_start;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .o_tick_pre (w_tick_pre),
        .o_tick     (w_p_tick)
    );

    always_comb begin
        w_h_wrap = (r_h == H_LAST);
        w_v_wrap = (r_v == V_LAST);
        w_h_nxt  = w_h_wrap ? '0 : r_h + 10'd1;
        w_v_nxt  = r_v;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_v + 10'd1;
        end
    end

    // Flags are decoded from the next coordinates so they land with x/y on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_tick_pre) begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= !in_window(w_h_nxt, H_SS, H_SE);
            r_vsync       <= !in_window(w_v_nxt, V_SS, V_SE);
            r_video_on    <= in_window(w_h_nxt, 10'd0, H_VIS) && in_window(w_v_nxt, 10'd0, V_VIS);
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap && w_v_wrap;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign vga.x           = r_h;
    assign vga.y           = r_v;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.video_on    = r_video_on;
    assign vga.p_tick      = w_p_tick;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a small-geometry instance for whole-frame behaviour and a
// default 640x480 instance for startup and line timing, both against a tick-count model.
module tb_vga_sync;

    localparam int SHD = 20, SHF = 3, SHS = 4, SHB = 5;
    localparam int SVD = 12, SVF = 2, SVS = 2, SVB = 3;
    localparam int SDIV = 3;
    localparam int SHT = SHD + SHF + SHS + SHB;
    localparam int SVT = SVD + SVF + SVS + SVB;

    localparam int DHD = 640, DHF = 16, DHS = 96, DHB = 48;
    localparam int DVD = 480, DVF = 10, DVS = 2, DVB = 33;
    localparam int DDIV = 4;

    // {p_tick, line_start, frame_start, hsync, vsync, video_on, x, y}
    localparam logic [25:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0};

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   c = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vga_sync_if vif_s ();
    vga_sync_if vif_d ();

    vga_sync #(
        .H_DISPLAY (SHD), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_DISPLAY (SVD), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .CLK_DIV   (SDIV)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .vga   (vif_s)
    );

    vga_sync dut_d (
        .clk   (clk),
        .reset (reset),
        .vga   (vif_d)
    );

    logic [25:0] obs_s, obs_d;
    assign obs_s = {vif_s.p_tick, vif_s.line_start, vif_s.frame_start, vif_s.hsync,
                    vif_s.vsync, vif_s.video_on, vif_s.x, vif_s.y};
    assign obs_d = {vif_d.p_tick, vif_d.line_start, vif_d.frame_start, vif_d.hsync,
                    vif_d.vsync, vif_d.video_on, vif_d.x, vif_d.y};

    // cc = clk edges sampled with reset high since the last reset; the raster
    // position is simply the number of elapsed pixel ticks folded onto the frame.
    function automatic logic [25:0] model(input int hd, hf, hs, hb, vd, vf, vs, vb, div, cc);
        int   ht, vt, n, p, xx, yy;
        logic pt, ls, fs, hsy, vsy, von;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        n   = (cc + 1) / div;
        pt  = (cc >= 1) && (((cc + 1) % div) == 0);
        p   = n % (ht * vt);
        xx  = p % ht;
        yy  = p / ht;
        ls  = pt && (n > 0) && (xx == 0);
        fs  = ls && (yy == 0);
        hsy = !((xx >= hd + hf) && (xx < hd + hf + hs));
        vsy = !((yy >= vd + vf) && (yy < vd + vf + vs));
        von = (n > 0) && (xx < hd) && (yy < vd);
        return {pt, ls, fs, hsy, vsy, von, 10'(xx), 10'(yy)};
    endfunction

    function automatic logic [25:0] model_s(input int cc);
        return model(SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, SDIV, cc);
    endfunction

    function automatic logic [25:0] model_d(input int cc);
        return model(DHD, DHF, DHS, DHB, DVD, DVF, DVS, DVB, DDIV, cc);
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) c = 0;
        else        c = c + 1;
        #1;
    endtask

    task automatic test_reset();
        int len;
        reset = 1'b0;
        len = $urandom_range(4, 1);
        for (int i = 0; i < len; i++) begin
            step();
            n_cmp += 2;
            if (obs_s !== RST_VEC) begin
                n_bad++;
                $display("FAIL reset_s cyc=%0d got=%h exp=%h", i, obs_s, RST_VEC);
            end
            if (obs_d !== RST_VEC) begin
                n_bad++;
                $display("FAIL reset_d cyc=%0d got=%h exp=%h", i, obs_d, RST_VEC);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_startup();
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp += 3;
            if (vif_d.p_tick !== ((c % 4) == 3)) begin
                n_bad++;
                $display("FAIL startup_ptick c=%0d got=%b exp=%b", c, vif_d.p_tick, (c % 4) == 3);
            end
            if (obs_d !== model_d(c)) begin
                n_bad++;
                $display("FAIL startup_d c=%0d got=%h exp=%h", c, obs_d, model_d(c));
            end
            if (obs_s !== model_s(c)) begin
                n_bad++;
                $display("FAIL startup_s c=%0d got=%h exp=%h", c, obs_s, model_s(c));
            end
        end
    endtask

    task automatic test_default_line();
        int hs_cnt = 0;
        int hs_first = -1;
        while (c < 3205) begin
            step();
            n_cmp += 2;
            if (obs_d !== model_d(c)) begin
                n_bad++;
                $display("FAIL line_d c=%0d got=%h exp=%h", c, obs_d, model_d(c));
            end
            if (obs_s !== model_s(c)) begin
                n_bad++;
                $display("FAIL line_s c=%0d got=%h exp=%h", c, obs_s, model_s(c));
            end
            if (((c + 1) % DDIV) == 0 && vif_d.y == 10'd0 && !vif_d.hsync) begin
                if (hs_cnt == 0) hs_first = int'(vif_d.x);
                hs_cnt++;
            end
            if (c == 3198) begin
                n_cmp++;
                if (vif_d.x !== 10'd799 || vif_d.y !== 10'd0) begin
                    n_bad++;
                    $display("FAIL dline_pre got x=%0d y=%0d exp x=799 y=0", vif_d.x, vif_d.y);
                end
            end
            if (c == 3199) begin
                n_cmp++;
                if ({vif_d.x, vif_d.y, vif_d.line_start, vif_d.frame_start} !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL dline_wrap got x=%0d y=%0d ls=%b fs=%b exp x=0 y=1 ls=1 fs=0",
                             vif_d.x, vif_d.y, vif_d.line_start, vif_d.frame_start);
                end
            end
            if (c == 3200) begin
                n_cmp++;
                if (vif_d.line_start !== 1'b0) begin
                    n_bad++;
                    $display("FAIL dline_pulse got ls=%b exp 0", vif_d.line_start);
                end
            end
        end
        n_cmp += 2;
        if (hs_cnt != DHS) begin
            n_bad++;
            $display("FAIL dhsync_len got=%0d exp=%0d", hs_cnt, DHS);
        end
        if (hs_first != DHD + DHF) begin
            n_bad++;
            $display("FAIL dhsync_start got=%0d exp=%0d", hs_first, DHD + DHF);
        end
    endtask

    // Runs the small instance to the tick that lands on (0, row) and checks the wrap.
    task automatic test_wrap(input int row, input string tag);
        int k = 0;
        int ct;
        logic [25:0] want;
        ct = (k * SHT * SVT + row * SHT) * SDIV - 1;
        while (ct <= c + 2) begin
            k++;
            ct = (k * SHT * SVT + row * SHT) * SDIV - 1;
        end
        while (c < ct + 1) begin
            step();
            n_cmp++;
            if (obs_s !== model_s(c)) begin
                n_bad++;
                $display("FAIL %s_run c=%0d got=%h exp=%h", tag, c, obs_s, model_s(c));
            end
            if (c == ct - 1) begin
                want = {1'b0, 1'b0, 1'b0, 10'(SHT - 1), 10'((row == 0) ? SVT - 1 : row - 1)};
                n_cmp++;
                if ({vif_s.p_tick, vif_s.line_start, vif_s.frame_start, vif_s.x, vif_s.y} !== want[22:0]) begin
                    n_bad++;
                    $display("FAIL %s_pre got x=%0d y=%0d exp x=%0d y=%0d", tag, vif_s.x, vif_s.y,
                             want[19:10], want[9:0]);
                end
            end
            if (c == ct) begin
                n_cmp++;
                if ({vif_s.p_tick, vif_s.line_start, vif_s.frame_start, vif_s.x, vif_s.y} !==
                    {1'b1, 1'b1, (row == 0), 10'd0, 10'(row)}) begin
                    n_bad++;
                    $display("FAIL %s_tick got pt=%b ls=%b fs=%b x=%0d y=%0d exp pt=1 ls=1 fs=%b x=0 y=%0d",
                             tag, vif_s.p_tick, vif_s.line_start, vif_s.frame_start, vif_s.x, vif_s.y,
                             row == 0, row);
                end
            end
            if (c == ct + 1) begin
                n_cmp++;
                if ({vif_s.p_tick, vif_s.line_start, vif_s.frame_start, vif_s.x, vif_s.y} !==
                    {1'b0, 1'b0, 1'b0, 10'd0, 10'(row)}) begin
                    n_bad++;
                    $display("FAIL %s_after got pt=%b ls=%b fs=%b x=%0d y=%0d exp pulses 0, x=0 y=%0d",
                             tag, vif_s.p_tick, vif_s.line_start, vif_s.frame_start, vif_s.x, vif_s.y, row);
                end
            end
        end
    endtask

    task automatic test_frame_stats();
        int k = 1;
        int cf, t;
        int hs_line = 0, hs_first = -1, vs_cnt = 0, vs_fx = -1, vs_fy = -1, vid = 0, viol = 0;
        cf = k * SHT * SVT * SDIV - 1;
        while (cf <= c) begin
            k++;
            cf = k * SHT * SVT * SDIV - 1;
        end
        while (c < cf + SHT * SVT * SDIV - 1) begin
            step();
            n_cmp++;
            if (obs_s !== model_s(c)) begin
                n_bad++;
                $display("FAIL stats_run c=%0d got=%h exp=%h", c, obs_s, model_s(c));
            end
            if (c >= cf && ((c + 1) % SDIV) == 0) begin
                t = (c - cf) / SDIV;
                if (!vif_s.hsync) begin
                    if (hs_first < 0) hs_first = int'(vif_s.x);
                    hs_line++;
                end
                if (!vif_s.vsync) begin
                    if (vs_cnt == 0) begin
                        vs_fx = int'(vif_s.x);
                        vs_fy = int'(vif_s.y);
                    end
                    vs_cnt++;
                end
                if (vif_s.video_on) begin
                    vid++;
                    if (vif_s.x >= 10'(SHD) || vif_s.y >= 10'(SVD)) viol++;
                end
                if ((t % SHT) == SHT - 1) begin
                    n_cmp++;
                    if (hs_line != SHS) begin
                        n_bad++;
                        $display("FAIL hsync_line line=%0d got=%0d exp=%0d", t / SHT, hs_line, SHS);
                    end
                    hs_line = 0;
                end
            end
        end
        n_cmp += 5;
        if (hs_first != SHD + SHF) begin
            n_bad++;
            $display("FAIL hsync_start got=%0d exp=%0d", hs_first, SHD + SHF);
        end
        if (vs_cnt != SVS * SHT) begin
            n_bad++;
            $display("FAIL vsync_len got=%0d exp=%0d", vs_cnt, SVS * SHT);
        end
        if (vs_fx != 0 || vs_fy != SVD + SVF) begin
            n_bad++;
            $display("FAIL vsync_start got x=%0d y=%0d exp x=0 y=%0d", vs_fx, vs_fy, SVD + SVF);
        end
        if (vid != SHD * SVD) begin
            n_bad++;
            $display("FAIL video_count got=%0d exp=%0d", vid, SHD * SVD);
        end
        if (viol != 0) begin
            n_bad++;
            $display("FAIL video_outside got=%0d exp=0", viol);
        end
    endtask

    task automatic test_random_run(input int len, input string tag);
        for (int i = 0; i < len; i++) begin
            step();
            n_cmp += 2;
            if (obs_s !== model_s(c)) begin
                n_bad++;
                $display("FAIL %s_s c=%0d got=%h exp=%h", tag, c, obs_s, model_s(c));
            end
            if (obs_d !== model_d(c)) begin
                n_bad++;
                $display("FAIL %s_d c=%0d got=%h exp=%h", tag, c, obs_d, model_d(c));
            end
        end
    endtask

    task automatic test_mid_reset();
        test_random_run($urandom_range(600, 100), "premid");
        test_reset();
        test_startup();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at c=%0d", c);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_default_line();
        test_wrap(11, "line_wrap");
        test_wrap(0, "frame_wrap");
        test_frame_stats();
        test_mid_reset();
        test_random_run($urandom_range(1500, 800), "random");
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch and sync widths in pixel ticks (line total 800).
REQ-003 Parameter V_DISPLAY, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical widths in lines (frame total 525).
REQ-004 Parameter CLK_DIV, 4, system clocks per pixel tick (100 MHz to 25 MHz).
REQ-005 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 video_on  output  1  high while the current pixel is in the visible area.
REQ-010 p_tick  output  1  one-clk pulse per pixel period.
REQ-011 x  output  10  current pixel column (v_x for downstream sprite and wall tile blocks).
REQ-012 y  output  10  current pixel row (v_y for downstream sprite and wall tile blocks).
REQ-013 line_start  output  1  one-clk pulse at the first tick of every line.
REQ-014 frame_start  output  1  one-clk pulse at the first tick of every frame.

Function
REQ-015 A mod-CLK_DIV divider SHALL count 0..CLK_DIV-1 and assert p_tick in the cycle the count equals CLK_DIV-1, giving exactly one p_tick per CLK_DIV clocks.
REQ-016 The horizontal counter SHALL advance only on p_tick and wrap from 799 to 0.
REQ-017 The vertical counter SHALL advance only on a p_tick in which the horizontal counter wraps, and SHALL wrap from 524 to 0.
REQ-018 The vertical counter at 524 with the horizontal counter at 799 SHALL wrap both counters to 0 on the same tick.
REQ-019 x and y SHALL equal the horizontal and vertical counters, registered, and SHALL hold steady between p_ticks.
REQ-020 hsync SHALL be 0 exactly while x is 656..751, and 1 otherwise.
REQ-021 vsync SHALL be 0 exactly while y is 490..491, and 1 otherwise.
REQ-022 video_on SHALL be 1 exactly while x < 640 and y < 480.
REQ-023 hsync, vsync and video_on SHALL be registered and SHALL describe the same pixel as the concurrent x and y (zero skew).
REQ-024 line_start SHALL pulse for one clk, coincident with p_tick, when the horizontal counter advances to 0.
REQ-025 frame_start SHALL pulse for one clk, coincident with p_tick, when both counters advance to 0.
REQ-026 All sync-window and visible-area comparisons SHALL be unsigned 10-bit, with boundaries derived from the parameters.

Reset
REQ-027 With reset low at a clk edge, the next cycle SHALL show: divider 0, counters 0, x=0, y=0, hsync=1, vsync=1, video_on=0, p_tick=0, line_start=0, frame_start=0.
REQ-028 Reset SHALL take priority over every tick and wrap event, including an assertion mid-frame.
REQ-029 After reset deasserts, the first p_tick SHALL occur on the CLK_DIV-th clk.
REQ-030 The first tick after reset deassertion SHALL advance x from 0 to 1, so no frame_start or line_start pulse occurs until the first wrap.

Structure
REQ-031 The VGA timing constants (display, porch and sync widths, and derived totals and sync start/end values) SHALL live in a shared package, because the sprite, wall and bomberman blocks also need them.
REQ-032 The clock divider SHALL be a separate sub-module, pixel_tick_gen, parameterised by CLK_DIV.
REQ-033 The block SHALL contain no combinational path from input to output; every output SHALL be a register.

Verification
REQ-034 Release reset at clk 0 -> p_tick high at clks 3, 7, 11, and so on; all outputs equal their reset values before clk 3.
REQ-035 Run to x=799, y=10, then one p_tick -> x=0, y=11, line_start=1 for exactly one clk, frame_start=0.
REQ-036 Run to x=799, y=524, then one p_tick -> x=0, y=0, line_start=1 and frame_start=1 together for one clk.
REQ-037 Over one full line -> hsync low for exactly 96 p_ticks starting at x=656; over one full frame -> vsync low for exactly 1600 p_ticks starting at y=490, x=0.
REQ-038 Over one full frame -> video_on high for exactly 307200 p_ticks, and never high with x>=640 or y>=480.
REQ-039 Assert reset at x=300, y=200 -> the next cycle shows all reset values; after release, timing restarts as in REQ-034.
